// File: rtl/amm_mem_pkg.sv
// Shared types and helpers for the Avalon-MM slave memory.
package amm_mem_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } stall_state_e;

    localparam int unsigned MAX_READ_LATENCY = 8;

    // Expands one byteenable bit into the bit mask of its byte lane.
    function automatic logic [7:0] lane_mask(input logic be_bit);
        return {8{be_bit}};
    endfunction

endpackage

// File: rtl/amm_mem_rd_pipe.sv
// Fixed-latency read return pipe: a valid/data shift register whose data
// stages only advance with a valid beat, so the output holds its last value.
module amm_mem_rd_pipe #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DW      = 64
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    output logic [DW-1:0] out_data_o
);

    logic [LATENCY-1:0]         vld_q;
    logic [LATENCY-1:0][DW-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q[0] <= in_valid_i;
            if (in_valid_i) begin
                data_q[0] <= in_data_i;
            end
            for (int i = 1; i < int'(LATENCY); i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid_o = vld_q[LATENCY-1];
    assign out_data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/amm_mem_slave.sv
// Avalon-MM slave memory with byte-masked writes, fixed-latency pipelined
// reads and a deterministic waitrequest stall pattern.
module amm_mem_slave
    import amm_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned BYTE_CNT     = DATA_WIDTH / 8,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned STALL_EVERY  = 4,
    parameter int unsigned STALL_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] writedata,
    input  logic [BYTE_CNT-1:0]   byteenable,
    output logic                  waitrequest,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic                  readdatavalid,
    output logic                  err
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((STALL_EVERY > 0) ? STALL_EVERY - 1 : 0);
    localparam logic [3:0] SC_LAST = 4'(STALL_CYCLES - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    stall_state_e     state_q, state_d;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
    logic [3:0]       stall_cnt_q, stall_cnt_d;
    logic             wait_q;
    logic             err_q;

    logic                  accept;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  viol;
    logic [DATA_WIDTH-1:0] wmask;

    assign accept = (read | write) & ~wait_q;
    assign wr_acc = write & ~wait_q;
    assign rd_acc = read & ~write & ~wait_q;
    assign viol   = read & write & ~wait_q;

    genvar gi;
    generate
        for (gi = 0; gi < BYTE_CNT; gi++) begin : g_mask
            assign wmask[gi*8 +: 8] = lane_mask(byteenable[gi]);
        end
    endgenerate

    // Memory is deliberately not reset; a simultaneous read is dropped but the write proceeds.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[address] <= (mem_q[address] & ~wmask) | (writedata & wmask);
        end
    end

    always_comb begin
        state_d     = state_q;
        xfer_cnt_d  = xfer_cnt_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            RUN: begin
                if (accept && (STALL_EVERY != 0)) begin
                    if (xfer_cnt_q == CNT_LAST) begin
                        state_d     = STALL;
                        xfer_cnt_d  = '0;
                        stall_cnt_d = '0;
                    end else begin
                        xfer_cnt_d = xfer_cnt_q + 1'b1;
                    end
                end
            end
            STALL: begin
                if (stall_cnt_q == SC_LAST) begin
                    state_d     = RUN;
                    stall_cnt_d = '0;
                end else begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // waitrequest is registered from next state; it comes out of reset high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            xfer_cnt_q  <= '0;
            stall_cnt_q <= '0;
            wait_q      <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            xfer_cnt_q  <= xfer_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            wait_q      <= (state_d == STALL);
            if (viol) begin
                err_q <= 1'b1;
            end
        end
    end

    amm_mem_rd_pipe #(
        .LATENCY (READ_LATENCY),
        .DW      (DATA_WIDTH)
    ) u_rd_pipe (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (rd_acc),
        .in_data_i   (mem_q[address]),
        .out_valid_o (readdatavalid),
        .out_data_o  (readdata)
    );

    assign waitrequest = wait_q;
    assign err         = err_q;

endmodule

// File: tb/tb_amm_mem_slave.sv
// Randomized bench for amm_mem_slave against a transaction-level memory model.
module tb_amm_mem_slave;

    localparam int DW = 64;
    localparam int AW = 10;
    localparam int BC = DW / 8;
    localparam int LAT = 2;
    localparam int SE = 4;
    localparam int SC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] address = '0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [DW-1:0] writedata = '0;
    logic [BC-1:0] byteenable = '0;
    logic          waitrequest;
    logic [DW-1:0] readdata;
    logic          readdatavalid;
    logic          err;

    amm_mem_slave #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .BYTE_CNT     (BC),
        .READ_LATENCY (LAT),
        .STALL_EVERY  (SE),
        .STALL_CYCLES (SC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .err           (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk64(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Transaction-level reference: memory array, stall budget, return queue.
    logic [DW-1:0] m_mem [2**AW];
    logic          m_wait = 1'b1;
    logic          m_rdv = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic          m_err = 1'b0;
    int            m_acc = 0;
    int            m_left = 0;
    int            cyc = 0;
    logic [DW-1:0] pend_d [$];
    int            pend_t [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wait = 1'b1;
            m_rdv = 1'b0;
            m_rdata = '0;
            m_err = 1'b0;
            m_acc = 0;
            m_left = 0;
            pend_d.delete();
            pend_t.delete();
        end else begin
            cyc++;
            if ((read || write) && !m_wait) begin
                if (read && write) begin
                    m_err = 1'b1;
                end else if (read) begin
                    pend_d.push_back(m_mem[address]);
                    pend_t.push_back(cyc + LAT - 1);
                end
                if (write) begin
                    for (int b = 0; b < BC; b++) begin
                        if (byteenable[b]) m_mem[address][b*8 +: 8] = writedata[b*8 +: 8];
                    end
                end
                m_acc++;
                if (SE != 0 && (m_acc % SE) == 0) m_left = SC;
            end
            m_wait = (m_left > 0);
            if (m_left > 0) m_left--;
            m_rdv = 1'b0;
            if (pend_t.size() > 0 && pend_t[0] == cyc) begin
                m_rdv = 1'b1;
                m_rdata = pend_d.pop_front();
                void'(pend_t.pop_front());
            end
        end
    end

    // Every-cycle comparison plus a log of observed read returns.
    logic [DW-1:0] got_d [$];
    int            got_c [$];
    int            wait_seen = 0;

    always @(negedge clk) begin
        chk1("waitrequest", waitrequest, m_wait);
        chk1("readdatavalid", readdatavalid, m_rdv);
        chk64("readdata", readdata, m_rdata);
        chk1("err", err, m_err);
        if (readdatavalid === 1'b1) begin
            got_d.push_back(readdata);
            got_c.push_back(cyc);
        end
        if (waitrequest === 1'b1) wait_seen++;
    end

    task automatic xfer(input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BC-1:0] be);
        int g;
        g = 0;
        read = rd;
        write = wr;
        address = a;
        writedata = d;
        byteenable = be;
        while (m_wait && g < 64) begin
            @(negedge clk);
            g++;
        end
        if (g >= 64) chki("xfer_timeout", g, 0);
        @(negedge clk);
        $display("XFER rd=%0d wr=%0d addr=%0d data=%h be=%h", rd, wr, a, d, be);
    endtask

    task automatic idle(input int n);
        read = 1'b0;
        write = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic read_check(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        int k;
        xfer(1'b1, 1'b0, a, '0, '0);
        read = 1'b0;
        write = 1'b0;
        k = 0;
        while (readdatavalid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chki({name, "_latency"}, k, LAT - 1);
        chk64({name, "_data"}, readdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk1("rst_waitrequest", waitrequest, 1'b1);
        chk1("rst_readdatavalid", readdatavalid, 1'b0);
        chk64("rst_readdata", readdata, '0);
        chk1("rst_err", err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("wait_drop_after_rst", waitrequest, 1'b0);

        // Full mask, then partial mask, each read back immediately.
        xfer(1'b0, 1'b1, 10'd5, 64'h1122334455667788, 8'hFF);
        read_check("full_mask", 10'd5, 64'h1122334455667788);
        xfer(1'b0, 1'b1, 10'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        read_check("partial_mask", 10'd5, 64'h11223344AAAAAAAA);

        // Pipelined reads of a preloaded ramp.
        for (int i = 0; i < 4; i++) xfer(1'b0, 1'b1, AW'(i), DW'(i), 8'hFF);
        got_d.delete();
        got_c.delete();
        for (int i = 0; i < 4; i++) xfer(1'b1, 1'b0, AW'(i), '0, '0);
        idle(6);
        chki("pipe_count", got_d.size(), 4);
        if (got_d.size() == 4) begin
            for (int i = 0; i < 4; i++) chk64("pipe_data", got_d[i], DW'(i));
            chki("pipe_back_to_back", got_c[3] - got_c[0], 3);
        end

        // Eight reads spanning two stall windows.
        got_d.delete();
        wait_seen = 0;
        for (int i = 0; i < 8; i++) xfer(1'b1, 1'b0, AW'(i % 4), '0, '0);
        idle(8);
        chki("stall_wait_cycles", wait_seen, 4);
        chki("stall_rdv_count", got_d.size(), 8);
        if (got_d.size() == 8) begin
            for (int i = 0; i < 8; i++) chk64("stall_order", got_d[i], DW'(i % 4));
        end

        // Randomized traffic over a preloaded window.
        for (int i = 0; i < 32; i++) xfer(1'b0, 1'b1, AW'(i), {$urandom, $urandom}, 8'hFF);
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0: idle($urandom_range(1, 2));
                1: xfer(1'b0, 1'b1, AW'($urandom_range(0, 31)), {$urandom, $urandom},
                        ($urandom_range(0, 7) == 0) ? 8'h00 : BC'($urandom));
                default: xfer(1'b1, 1'b0, AW'($urandom_range(0, 31)), '0, '0);
            endcase
        end
        idle(8);

        // Simultaneous read and write: write lands, read dropped, err sticky.
        got_d.delete();
        xfer(1'b1, 1'b1, 10'd7, 64'h55, 8'hFF);
        idle(100);
        chk1("viol_err_sticky", err, 1'b1);
        chki("viol_no_rdv", got_d.size(), 0);
        read_check("viol_mem", 10'd7, 64'h55);
        idle(4);

        // Reset one cycle after a read is accepted.
        got_d.delete();
        xfer(1'b1, 1'b0, 10'd3, '0, '0);
        read = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk1("midrst_waitrequest", waitrequest, 1'b1);
        chk1("midrst_readdatavalid", readdatavalid, 1'b0);
        chk1("midrst_err", err, 1'b0);
        repeat (3) @(negedge clk);
        chk1("midrst_rdv_held", readdatavalid, 1'b0);
        #2 rst_n = 1'b1;
        idle(10);
        chki("midrst_no_late_rdv", got_d.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
